canright_inv_sbox_seq: RTL and testbench
========================================

// Module: canright_inv_sbox_seq
// PURPOSE
//  Multi-cycle AES inverse S-box (InvSubBytes) built on the Canright tower-field
//  GF(((2^2)^2)^2) inverter. Decryption-side counterpart of the forward Canright
//  S-box. Sits between a byte source and a byte sink, using valid/ready on both.
//  It shares the GF inverter and basis matrices with the forward path.
// PARAMETERS
//  COUNT_W  8  width of the processed-byte counter (wraps modulo 2^COUNT_W)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        source presents in_data
//  in_ready   out  1        block can accept a byte this cycle
//  in_data    in   8        ciphertext-domain byte y
//  out_valid  out  1        out_data holds a finished result
//  out_ready  in   1        sink consumes out_data this cycle
//  out_data   out  8        InvSbox(y)
//  busy       out  1        state != IDLE
//  byte_count out  COUNT_W  number of completed output handshakes
// BEHAVIOUR
//  Function: out = GFinv(Ainv(y ^ 8'h63)), with GFinv(0)=0 and AES poly 0x11B.
//   Ainv and the basis change into tower form are merged into one 8x8 GF(2)
//   matrix. The output basis change is a separate matrix.
//  Reset (async, while rst=1): state=IDLE, out_valid=0, out_data=8'h00,
//   byte_count=0, all internal stage registers cleared.
//  FSM states:
//   IDLE -> MAP  on in_valid&&in_ready. Latch in_data into the input register.
//   MAP  -> INV  register the tower-basis value a = M_in*(y^63). Split into hi/lo nibbles.
//   INV  -> MUL  register d^-1 in GF(2^4), where d = hi*lo ^ (hi^lo)^2*N.
//   MUL  -> DONE register M_out*{lo*dinv, hi*dinv} into out_data. out_valid=1.
//   DONE: hold out_data/out_valid stable until out_ready.
//    out_ready && !in_valid -> IDLE, out_valid=0.
//    out_ready &&  in_valid -> MAP. Accept the new byte in the same cycle.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational
//   from out_ready; no other comb path runs from inputs to outputs.
//  Latency: accept edge k -> out_valid high after edge k+3. Back-to-back
//   throughput is 1 byte per 4 cycles with out_ready held high.
//  in_data is sampled only on the accept edge. Later changes have no effect.
//  in_valid with no accept (busy) is ignored. The source must hold it.
//  byte_count increments on each out_valid&&out_ready and wraps 2^COUNT_W-1 -> 0.
//  Input 8'h63 maps to a=0. The inverter must yield 0 (d=0 gives dinv=0),
//   so the output is 8'h00.
//  Reset asserted mid-operation: the in-flight byte is discarded and not
//   counted. After release the block is in IDLE with in_ready=1.
//  out_ready while out_valid=0 has no effect.
// STRUCTURE
//  Package canright_pkg:
//   - localparam 8x8 basis matrices M_IN_INV (merged with Ainv) and M_OUT.
//   - the AES constant 8'h63.
//   - GF(2^2) and GF(2^4) mul/square/scale functions in normal basis,
//     shared with the forward S-box.
//  Sub-module canright_gf16_inv: combinational GF(2^4) inverse (4b in, 4b out),
//   instantiated once, between the MAP and INV registers.
//  FSM and datapath registers live in this module.
// TESTING
//  1 Reset mid-op: accept 8'h52, assert rst at cycle 2 -> out_valid stays 0,
//    byte_count=0, in_ready=1 after release.
//  2 Single byte: in 8'h63 -> out 8'h00; in 8'h7c -> 8'h01; in 8'h16 -> 8'hff;
//    in 8'h00 -> 8'h52; in 8'hed -> 8'h53. out_valid rises exactly 3 edges after accept.
//  3 Backpressure: out_ready=0 for 10 cycles after in 8'h7c -> out_data holds
//    8'h01, in_ready=0, a second in_valid is not accepted until the handshake.
//  4 Streaming: in_valid and out_ready held high, inputs 0x00..0x0f -> one result
//    every 4 cycles in order; byte_count=16.
//  5 Exhaustive: all 256 y -> out equals the inverse of the AES S-box table.
//    Forward S-box(out)==y for every y.
//  6 Counter wrap (COUNT_W=4): 17 transfers -> byte_count=1.

Source files
------------

// File: rtl/canright_pkg.sv
// Canright tower-field GF(((2^2)^2)^2) arithmetic in normal basis and the basis
// matrices shared by the forward and inverse S-box datapaths.
package canright_pkg;

    localparam logic [7:0] AES_C = 8'h63;

    typedef enum logic [2:0] {IDLE, MAP, INV, MUL, DONE} state_t;

    // GF(2^2) normal basis {W^2, W}; N = W^2 makes z^2+z+N irreducible over GF(4).
    localparam logic [1:0] GF4_N = 2'b10;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic s;
        s = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ s, (a[0] & b[0]) ^ s};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [1:0] gf4_scl_n(input logic [1:0] a);
        return gf4_mul(a, GF4_N);
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] s;
        s = gf4_scl_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {gf4_mul(a[3:2], b[3:2]) ^ s, gf4_mul(a[1:0], b[1:0]) ^ s};
    endfunction

    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return gf16_mul(a, a);
    endfunction

    // Smallest nu for which y^2+y+nu has no root in GF(16), i.e. is irreducible.
    function automatic logic [3:0] find_nu();
        logic [3:0] r;
        logic       hit;
        r = 4'h0;
        for (int c = 15; c >= 1; c--) begin
            hit = 1'b0;
            for (int t = 0; t < 16; t++)
                if ((gf16_sq(4'(t)) ^ 4'(t)) == 4'(c)) hit = 1'b1;
            if (!hit) r = 4'(c);
        end
        return r;
    endfunction

    localparam logic [3:0] GF16_NU = find_nu();

    function automatic logic [3:0] gf16_scl_nu(input logic [3:0] a);
        return gf16_mul(a, GF16_NU);
    endfunction

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] s;
        s = gf16_scl_nu(gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]));
        return {gf16_mul(a[7:4], b[7:4]) ^ s, gf16_mul(a[3:0], b[3:0]) ^ s};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Column i of m is the image of input bit i.
    function automatic logic [7:0] mat_mul8(input logic [7:0][7:0] m, input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (x[i]) r ^= m[i];
        return r;
    endfunction

    // A tower element that is a root of the AES polynomial; the tower "one" is 8'hFF.
    function automatic logic [7:0] find_root();
        logic [8:0][7:0] p;
        logic [7:0]      r;
        r = 8'h00;
        for (int g = 255; g >= 1; g--) begin
            p[0] = 8'hFF;
            for (int i = 1; i <= 8; i++) p[i] = gf256_mul(p[i-1], 8'(g));
            if ((p[8] ^ p[4] ^ p[3] ^ p[1] ^ p[0]) == 8'h00) r = 8'(g);
        end
        return r;
    endfunction

    function automatic logic [7:0][7:0] build_m_tower(input logic [7:0] g);
        logic [7:0][7:0] m;
        m[0] = 8'hFF;
        for (int i = 1; i < 8; i++) m[i] = gf256_mul(m[i-1], g);
        return m;
    endfunction

    // Inverse affine linear part folded in front of the polynomial-to-tower map.
    function automatic logic [7:0][7:0] merge_ainv(input logic [7:0][7:0] mt);
        logic [7:0][7:0] m;
        logic [7:0]      e;
        for (int j = 0; j < 8; j++) begin
            e    = 8'(1 << j);
            m[j] = mat_mul8(mt, rotl8(e, 1) ^ rotl8(e, 3) ^ rotl8(e, 6));
        end
        return m;
    endfunction

    function automatic logic [7:0][7:0] invert_map(input logic [7:0][7:0] mt);
        logic [7:0][7:0] m;
        m = '0;
        for (int j = 0; j < 8; j++)
            for (int b = 0; b < 256; b++)
                if (mat_mul8(mt, 8'(b)) == 8'(1 << j)) m[j] = 8'(b);
        return m;
    endfunction

    localparam logic [7:0]      G_ROOT   = find_root();
    localparam logic [7:0][7:0] M_TOWER  = build_m_tower(G_ROOT);
    localparam logic [7:0][7:0] M_IN_INV = merge_ainv(M_TOWER);
    localparam logic [7:0][7:0] M_OUT    = invert_map(M_TOWER);

endpackage

// File: rtl/canright_inv_sbox_seq_gf16_inv.sv
// Combinational GF(2^4) inverse over GF(2^2) in normal basis; maps 0 to 0.
module canright_gf16_inv
    import canright_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] a_inv
);

    logic [1:0] hi;
    logic [1:0] lo;
    logic [1:0] d;
    logic [1:0] d_inv;

    assign hi    = a[3:2];
    assign lo    = a[1:0];
    assign d     = gf4_mul(hi, lo) ^ gf4_scl_n(gf4_sq(hi ^ lo));
    // In GF(4) the inverse is the square, which also sends 0 to 0.
    assign d_inv = gf4_sq(d);
    assign a_inv = {gf4_mul(lo, d_inv), gf4_mul(hi, d_inv)};

endmodule

// File: rtl/canright_inv_sbox_seq.sv
// Four-stage AES inverse S-box: input register, tower-basis map, GF(16) inverse,
// final multiply and basis change, with valid/ready on both sides.
module canright_inv_sbox_seq
    import canright_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               busy,
    output logic [COUNT_W-1:0] byte_count
);

    // Handshake: a byte moves on any rising edge where valid && ready are both high;
    // out_valid/out_data stay stable until that edge, and in_ready depends on
    // out_ready only so a finished byte and a new byte can swap in one cycle.
    state_t     state;
    state_t     state_nxt;
    logic [7:0] y_reg;
    logic [7:0] a_reg;
    logic [3:0] dinv_reg;
    logic [3:0] a_hi;
    logic [3:0] a_lo;
    logic [3:0] d;
    logic [3:0] d_inv;
    logic [7:0] map_val;
    logic [7:0] res_val;
    logic       accept;
    logic       fire;

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    assign a_hi    = a_reg[7:4];
    assign a_lo    = a_reg[3:0];
    assign map_val = mat_mul8(M_IN_INV, y_reg ^ AES_C);
    assign d       = gf16_mul(a_hi, a_lo) ^ gf16_scl_nu(gf16_sq(a_hi ^ a_lo));
    assign res_val = mat_mul8(M_OUT, {gf16_mul(a_lo, dinv_reg), gf16_mul(a_hi, dinv_reg)});

    canright_gf16_inv u_gf16_inv (
        .a     (d),
        .a_inv (d_inv)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAP;
            MAP:     state_nxt = INV;
            INV:     state_nxt = MUL;
            MUL:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? MAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            y_reg      <= 8'h00;
            a_reg      <= 8'h00;
            dinv_reg   <= 4'h0;
            out_data   <= 8'h00;
            byte_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)         y_reg      <= in_data;
            if (state == MAP)   a_reg      <= map_val;
            if (state == INV)   dinv_reg   <= d_inv;
            if (state == MUL)   out_data   <= res_val;
            if (fire)           byte_count <= byte_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_canright_inv_sbox_seq.sv
// Randomized scoreboard bench for canright_inv_sbox_seq against a GF(2^8)
// reference built from field inversion and the forward affine transform.
module tb_canright_inv_sbox_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_data;
    logic [7:0] byte_count;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] out_data4;
    logic [3:0] byte_count4;

    canright_inv_sbox_seq #(.COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .byte_count(byte_count)
    );

    canright_inv_sbox_seq #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .busy(busy4), .byte_count(byte_count4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         hs_count = 0;
    int         ready_mode = 0;
    int         last_accept = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] y_q[$];
    int         due_q[$];
    logic [7:0] fwd_tab[256];
    logic [7:0] ref_inv[256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) r = 8'(b);
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = ginv(8'(x));
            fwd_tab[x] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) ref_inv[fwd_tab[x]] = 8'(x);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_sample();
        @(negedge clk);
        #4;
    endtask

    task automatic send_byte(input logic [7:0] y, input logic [7:0] exp, input bit track);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = y;
        budget   = 0;
        forever begin
            #4;
            if (in_ready) break;
            budget++;
            if (budget > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: byte %0h not accepted, required accept within 200 cycles", y);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (track) begin
            exp_q.push_back(exp);
            y_q.push_back(y);
            due_q.push_back(cyc + 4);
        end
        last_accept = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle_inputs(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            at_sample();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
            y_q.delete();
            due_q.delete();
        end
        at_sample();
        at_sample();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        hs_count = 0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- sink ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [7:0] e, y;
        int         d;
        forever begin
            at_sample();
            if (rst) begin
                prev_valid = 1'b0;
                continue;
            end
            if (out_valid && !prev_valid) begin
                if (due_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: out_valid=1 with data %0h, required no result", out_data);
                end else begin
                    check("latency", cyc, due_q[0]);
                end
            end
            prev_valid = out_valid;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                y = y_q.pop_front();
                d = due_q.pop_front();
                check("out_data", out_data, e);
                check("fwd_sbox_of_out", fwd_tab[out_data], y);
                check("out_data_cnt4", {out_valid4, out_data4}, {1'b1, e});
                hs_count++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] dir_in[5]  = '{8'h63, 8'h7c, 8'h16, 8'h00, 8'hed};
        logic [7:0] dir_out[5] = '{8'h00, 8'h01, 8'hff, 8'h52, 8'h53};
        logic [7:0] ry;
        int         prev_acc;
        int         budget;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        build_tables();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        at_sample();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_byte_count", byte_count, 8'h00);
        check("reset_byte_count4", byte_count4, 4'h0);
        check("reset_busy", {busy, busy4}, 2'b00);
        check("reset_in_ready", {in_ready, in_ready4}, 2'b11);

        // Reset in the middle of a byte: nothing may come out or be counted.
        ready_mode = 1;
        send_byte(8'h52, 8'h00, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        do_reset();
        repeat (6) begin
            at_sample();
            check("midrst_out_valid", out_valid, 1'b0);
        end
        check("midrst_byte_count", byte_count, 8'h00);
        check("midrst_in_ready", in_ready, 1'b1);

        // Directed single bytes with idle gaps.
        for (int i = 0; i < 5; i++) begin
            send_byte(dir_in[i], dir_out[i], 1'b1);
            idle_inputs(6);
        end
        drain();

        // Backpressure: the result must hold while the sink stalls.
        ready_mode = 0;
        send_byte(8'h7c, 8'h01, 1'b1);
        fork
            send_byte(8'h00, 8'h52, 1'b1);
            begin
                budget = 0;
                at_sample();
                while (!out_valid && budget < 20) begin
                    at_sample();
                    budget++;
                end
                for (int i = 0; i < 10; i++) begin
                    check("bp_out_valid", out_valid, 1'b1);
                    check("bp_out_data", out_data, 8'h01);
                    check("bp_in_ready", in_ready, 1'b0);
                    at_sample();
                end
                ready_mode = 1;
            end
        join
        idle_inputs(1);
        drain();

        // Streaming with in_valid and out_ready held high.
        do_reset();
        ready_mode = 1;
        prev_acc = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), ref_inv[i], 1'b1);
            if (i > 0) check("stream_spacing", last_accept - prev_acc, 4);
            prev_acc = last_accept;
        end
        idle_inputs(1);
        drain();
        check("stream_byte_count", byte_count, 8'd16);

        // Seventeenth transfer wraps the 4-bit counter to 1.
        ry = 8'($urandom_range(0, 255));
        send_byte(ry, ref_inv[ry], 1'b1);
        idle_inputs(1);
        drain();
        check("wrap_byte_count", byte_count, 8'd17);
        check("wrap_byte_count4", byte_count4, 4'd1);

        // Exhaustive sweep, then random bytes, with a randomly stalling sink.
        ready_mode = 2;
        for (int y = 0; y < 256; y++) begin
            send_byte(8'(y), ref_inv[y], 1'b1);
            if ($urandom_range(0, 3) == 0) idle_inputs($urandom_range(0, 2));
        end
        for (int i = 0; i < 64; i++) begin
            ry = 8'($urandom);
            send_byte(ry, ref_inv[ry], 1'b1);
        end
        idle_inputs(1);
        ready_mode = 1;
        drain();
        check("final_byte_count", byte_count, 8'(hs_count));
        check("final_byte_count4", byte_count4, 4'(hs_count));
        check("final_idle", {busy, out_valid, in_ready}, 3'b001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
